// File: rtl/logic_axi4_lite_write_aligner_fifo.sv
// AXI4-Lite write aligner: AW and W beats are buffered independently and released
// downstream as a matched pair, with a cap on writes still awaiting a B response.

module logic_axi4_lite_write_aligner_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             filled,
  output logic             more
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push;

  assign push       = push_valid && push_ready;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // Ready is registered from the post-update fill level, so a full FIFO that is
  // popped keeps ready low for that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      push_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count      <= count_next;
      push_ready <= (count_next != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head   = mem[rd_ptr];
  assign filled = (count != '0);
  assign more   = (count > CNT_W'(1));
endmodule

module logic_axi4_lite_write_aligner_fifo #(
  parameter int DATA_BYTES      = 4,
  parameter int ADDRESS_WIDTH   = 1,
  parameter int AW_DEPTH        = 2,
  parameter int W_DEPTH         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic                                 slave_awvalid,
  output logic                                 slave_awready,
  input  logic [ADDRESS_WIDTH-1:0]             slave_awaddr,
  input  logic [2:0]                           slave_awprot,
  input  logic                                 slave_wvalid,
  output logic                                 slave_wready,
  input  logic [8*DATA_BYTES-1:0]              slave_wdata,
  input  logic [DATA_BYTES-1:0]                slave_wstrb,
  output logic                                 slave_bvalid,
  input  logic                                 slave_bready,
  output logic [1:0]                           slave_bresp,
  input  logic                                 slave_arvalid,
  output logic                                 slave_arready,
  input  logic [ADDRESS_WIDTH-1:0]             slave_araddr,
  input  logic [2:0]                           slave_arprot,
  output logic                                 slave_rvalid,
  input  logic                                 slave_rready,
  output logic [8*DATA_BYTES-1:0]              slave_rdata,
  output logic [1:0]                           slave_rresp,
  output logic                                 master_awvalid,
  input  logic                                 master_awready,
  output logic [ADDRESS_WIDTH-1:0]             master_awaddr,
  output logic [2:0]                           master_awprot,
  output logic                                 master_wvalid,
  input  logic                                 master_wready,
  output logic [8*DATA_BYTES-1:0]              master_wdata,
  output logic [DATA_BYTES-1:0]                master_wstrb,
  input  logic                                 master_bvalid,
  output logic                                 master_bready,
  input  logic [1:0]                           master_bresp,
  output logic                                 master_arvalid,
  input  logic                                 master_arready,
  output logic [ADDRESS_WIDTH-1:0]             master_araddr,
  output logic [2:0]                           master_arprot,
  input  logic                                 master_rvalid,
  output logic                                 master_rready,
  input  logic [8*DATA_BYTES-1:0]              master_rdata,
  input  logic [1:0]                           master_rresp,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 busy
);
  localparam int DATA_W  = 8 * DATA_BYTES;
  localparam int AW_ENT  = ADDRESS_WIDTH + 3;
  localparam int W_ENT   = DATA_W + DATA_BYTES;
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, AW_DONE, W_DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [AW_ENT-1:0] aw_head;
  logic [W_ENT-1:0]  w_head;
  logic              aw_filled;
  logic              aw_more;
  logic              w_filled;
  logic              w_more;
  logic              pair_done;
  logic              b_fire;
  logic              b_dec;
  logic [OUT_W-1:0]  out_next;

  logic_axi4_lite_write_aligner_fifo_buf #(.WIDTH(AW_ENT), .DEPTH(AW_DEPTH)) aw_fifo (
    .clk        (aclk),
    .rst        (areset),
    .push_valid (slave_awvalid),
    .push_ready (slave_awready),
    .push_data  ({slave_awprot, slave_awaddr}),
    .pop        (pair_done),
    .head       (aw_head),
    .filled     (aw_filled),
    .more       (aw_more)
  );

  logic_axi4_lite_write_aligner_fifo_buf #(.WIDTH(W_ENT), .DEPTH(W_DEPTH)) w_fifo (
    .clk        (aclk),
    .rst        (areset),
    .push_valid (slave_wvalid),
    .push_ready (slave_wready),
    .push_data  ({slave_wstrb, slave_wdata}),
    .pop        (pair_done),
    .head       (w_head),
    .filled     (w_filled),
    .more       (w_more)
  );

  // A pair completes when the last outstanding half of it handshakes.
  assign pair_done = ((state == ISSUE)   && master_awready && master_wready) ||
                     ((state == AW_DONE) && master_wready) ||
                     ((state == W_DONE)  && master_awready);
  assign b_fire    = master_bvalid && slave_bready;
  assign b_dec     = b_fire && (outstanding != '0);

  always_comb begin
    out_next = outstanding;
    if (pair_done && !b_dec)      out_next = outstanding + 1'b1;
    else if (!pair_done && b_dec) out_next = outstanding - 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (aw_filled && w_filled && (outstanding < MAX_CNT)) state_next = ISSUE;
      ISSUE:   if (master_awready && !master_wready) state_next = AW_DONE;
               else if (!master_awready && master_wready) state_next = W_DONE;
      AW_DONE: state_next = AW_DONE;
      W_DONE:  state_next = W_DONE;
      default: state_next = IDLE;
    endcase
    // Heads after the pop must both still hold an entry to go back-to-back.
    if (pair_done) state_next = (aw_more && w_more && (out_next < MAX_CNT)) ? ISSUE : IDLE;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      outstanding <= '0;
    end else begin
      state       <= state_next;
      outstanding <= out_next;
    end
  end

  assign master_awvalid = (state == ISSUE) || (state == W_DONE);
  assign master_wvalid  = (state == ISSUE) || (state == AW_DONE);
  assign {master_awprot, master_awaddr} = aw_head;
  assign {master_wstrb, master_wdata}   = w_head;

  assign slave_bvalid  = master_bvalid;
  assign slave_bresp   = master_bresp;
  assign master_bready = slave_bready;

  assign master_arvalid = slave_arvalid;
  assign master_araddr  = slave_araddr;
  assign master_arprot  = slave_arprot;
  assign slave_arready  = master_arready;
  assign slave_rvalid   = master_rvalid;
  assign slave_rdata    = master_rdata;
  assign slave_rresp    = master_rresp;
  assign master_rready  = slave_rready;

  assign busy = aw_filled || w_filled || (state != IDLE) || (outstanding != '0);

  // A B response with nothing outstanding is a downstream protocol violation.
  b_without_write: assert property (@(posedge aclk) disable iff (areset)
    !(b_fire && (outstanding == '0)));
endmodule

// File: tb/tb_logic_axi4_lite_write_aligner_fifo.sv
// Directed bench for the AXI4-Lite write aligner: pairing, back-pressure,
// outstanding limit, read pass-through and mid-transaction reset.

module tb_logic_axi4_lite_write_aligner_fifo;
  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic        slave_awvalid = 1'b0, slave_awready;
  logic [0:0]  slave_awaddr = '0;
  logic [2:0]  slave_awprot = '0;
  logic        slave_wvalid = 1'b0, slave_wready;
  logic [31:0] slave_wdata = '0;
  logic [3:0]  slave_wstrb = '0;
  logic        slave_bvalid, slave_bready = 1'b0;
  logic [1:0]  slave_bresp;
  logic        slave_arvalid = 1'b0, slave_arready;
  logic [0:0]  slave_araddr = '0;
  logic [2:0]  slave_arprot = '0;
  logic        slave_rvalid, slave_rready = 1'b0;
  logic [31:0] slave_rdata;
  logic [1:0]  slave_rresp;
  logic        master_awvalid, master_awready = 1'b0;
  logic [0:0]  master_awaddr;
  logic [2:0]  master_awprot;
  logic        master_wvalid, master_wready = 1'b0;
  logic [31:0] master_wdata;
  logic [3:0]  master_wstrb;
  logic        master_bvalid = 1'b0, master_bready;
  logic [1:0]  master_bresp = '0;
  logic        master_arvalid, master_arready = 1'b0;
  logic [0:0]  master_araddr;
  logic [2:0]  master_arprot;
  logic        master_rvalid = 1'b0, master_rready;
  logic [31:0] master_rdata = '0;
  logic [1:0]  master_rresp = '0;
  logic [2:0]  outstanding;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  logic_axi4_lite_write_aligner_fifo dut (
    .aclk(aclk), .areset(areset),
    .slave_awvalid(slave_awvalid), .slave_awready(slave_awready),
    .slave_awaddr(slave_awaddr), .slave_awprot(slave_awprot),
    .slave_wvalid(slave_wvalid), .slave_wready(slave_wready),
    .slave_wdata(slave_wdata), .slave_wstrb(slave_wstrb),
    .slave_bvalid(slave_bvalid), .slave_bready(slave_bready), .slave_bresp(slave_bresp),
    .slave_arvalid(slave_arvalid), .slave_arready(slave_arready),
    .slave_araddr(slave_araddr), .slave_arprot(slave_arprot),
    .slave_rvalid(slave_rvalid), .slave_rready(slave_rready),
    .slave_rdata(slave_rdata), .slave_rresp(slave_rresp),
    .master_awvalid(master_awvalid), .master_awready(master_awready),
    .master_awaddr(master_awaddr), .master_awprot(master_awprot),
    .master_wvalid(master_wvalid), .master_wready(master_wready),
    .master_wdata(master_wdata), .master_wstrb(master_wstrb),
    .master_bvalid(master_bvalid), .master_bready(master_bready), .master_bresp(master_bresp),
    .master_arvalid(master_arvalid), .master_arready(master_arready),
    .master_araddr(master_araddr), .master_arprot(master_arprot),
    .master_rvalid(master_rvalid), .master_rready(master_rready),
    .master_rdata(master_rdata), .master_rresp(master_rresp),
    .outstanding(outstanding), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic b_drain(input int n);
    for (int i = 0; i < n; i++) begin
      master_bvalid = 1'b1;
      slave_bready  = 1'b1;
      tick();
    end
    master_bvalid = 1'b0;
    slave_bready  = 1'b0;
  endtask

  logic [0:0]  aw_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] w_tab  [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  int          exp_aw_cyc [4] = '{1, 2, 7, 8};
  int          exp_p_cyc  [4] = '{6, 7, 9, 10};
  int          aw_cyc [4];
  int          p_cyc  [4];
  logic [0:0]  p_addr [4];
  logic [31:0] p_data [4];
  int          aw_i, w_i, p_i;
  logic        aw_fire, w_fire;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check_eq("rst awready", 64'(slave_awready), 64'h0);
    check_eq("rst wready", 64'(slave_wready), 64'h0);
    check_eq("rst m_awvalid", 64'(master_awvalid), 64'h0);
    check_eq("rst m_wvalid", 64'(master_wvalid), 64'h0);
    check_eq("rst outstanding", 64'(outstanding), 64'h0);
    check_eq("rst busy", 64'(busy), 64'h0);
    areset = 1'b0;
    tick();
    check_eq("rel awready", 64'(slave_awready), 64'h1);
    check_eq("rel wready", 64'(slave_wready), 64'h1);

    // Single write: AW first, W three cycles later.
    slave_awvalid = 1'b1; slave_awaddr = 1'b1; slave_awprot = 3'd2;
    tick();
    slave_awvalid = 1'b0;
    check_eq("t1 busy aw queued", 64'(busy), 64'h1);
    tick(); tick();
    slave_wvalid = 1'b1; slave_wdata = 32'hDEADBEEF; slave_wstrb = 4'hF;
    tick();
    slave_wvalid = 1'b0;
    check_eq("t1 no bypass", 64'(master_awvalid), 64'h0);
    tick();
    check_eq("t1 awvalid", 64'(master_awvalid), 64'h1);
    check_eq("t1 wvalid", 64'(master_wvalid), 64'h1);
    check_eq("t1 awaddr", 64'(master_awaddr), 64'h1);
    check_eq("t1 awprot", 64'(master_awprot), 64'h2);
    check_eq("t1 wdata", 64'(master_wdata), 64'hDEADBEEF);
    check_eq("t1 wstrb", 64'(master_wstrb), 64'hF);
    master_awready = 1'b1; master_wready = 1'b1;
    tick();
    master_awready = 1'b0; master_wready = 1'b0;
    check_eq("t1 outstanding 1", 64'(outstanding), 64'h1);
    check_eq("t1 awvalid drop", 64'(master_awvalid), 64'h0);
    master_bvalid = 1'b1; master_bresp = 2'b10; slave_bready = 1'b1;
    #1;
    check_eq("t1 bvalid pass", 64'(slave_bvalid), 64'h1);
    check_eq("t1 bresp pass", 64'(slave_bresp), 64'h2);
    check_eq("t1 bready pass", 64'(master_bready), 64'h1);
    tick();
    master_bvalid = 1'b0; slave_bready = 1'b0; master_bresp = 2'b00;
    check_eq("t1 outstanding 0", 64'(outstanding), 64'h0);
    check_eq("t1 busy idle", 64'(busy), 64'h0);

    // Four AWs back-to-back, W stream delayed three cycles.
    master_awready = 1'b1; master_wready = 1'b1;
    aw_i = 0; w_i = 0; p_i = 0;
    for (int c = 1; c <= 12; c++) begin
      if (aw_i < 4) begin slave_awvalid = 1'b1; slave_awaddr = aw_tab[aw_i]; end
      else slave_awvalid = 1'b0;
      if (c > 3 && w_i < 4) begin slave_wvalid = 1'b1; slave_wdata = w_tab[w_i]; slave_wstrb = 4'hF; end
      else slave_wvalid = 1'b0;
      #1;
      if (c == 3) check_eq("t2 awready full", 64'(slave_awready), 64'h0);
      aw_fire = slave_awvalid && slave_awready;
      w_fire  = slave_wvalid && slave_wready;
      if (aw_fire) aw_cyc[aw_i] = c;
      if (master_awvalid && master_wvalid && p_i < 4) begin
        p_cyc[p_i] = c; p_addr[p_i] = master_awaddr; p_data[p_i] = master_wdata; p_i++;
      end
      tick();
      if (aw_fire) aw_i++;
      if (w_fire) w_i++;
    end
    slave_awvalid = 1'b0; slave_wvalid = 1'b0;
    check_eq("t2 pair count", 64'(p_i), 64'h4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t2 aw accept %0d", k), 64'(aw_cyc[k]), 64'(exp_aw_cyc[k]));
      check_eq($sformatf("t2 pair cyc %0d", k), 64'(p_cyc[k]), 64'(exp_p_cyc[k]));
      check_eq($sformatf("t2 pair addr %0d", k), 64'(p_addr[k]), 64'(aw_tab[k]));
      check_eq($sformatf("t2 pair data %0d", k), 64'(p_data[k]), 64'(w_tab[k]));
    end
    check_eq("t2 outstanding 4", 64'(outstanding), 64'h4);
    master_awready = 1'b0; master_wready = 1'b0;
    b_drain(4);
    check_eq("t2 drained", 64'(outstanding), 64'h0);

    // W back-pressure: AW accepted first, W held five cycles.
    master_awready = 1'b1; master_wready = 1'b0;
    slave_awvalid = 1'b1; slave_awaddr = 1'b1;
    slave_wvalid = 1'b1; slave_wdata = 32'hCAFEF00D; slave_wstrb = 4'h5;
    tick();
    slave_awvalid = 1'b0; slave_wvalid = 1'b0;
    tick();
    check_eq("t3 issue awvalid", 64'(master_awvalid), 64'h1);
    check_eq("t3 issue wvalid", 64'(master_wvalid), 64'h1);
    tick();
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t3 awdone awvalid %0d", k), 64'(master_awvalid), 64'h0);
      check_eq($sformatf("t3 awdone wvalid %0d", k), 64'(master_wvalid), 64'h1);
      check_eq($sformatf("t3 awdone wdata %0d", k), 64'(master_wdata), 64'hCAFEF00D);
      check_eq($sformatf("t3 awdone wstrb %0d", k), 64'(master_wstrb), 64'h5);
      tick();
    end
    master_wready = 1'b1;
    tick();
    master_wready = 1'b0; master_awready = 1'b0;
    check_eq("t3 wvalid after pop", 64'(master_wvalid), 64'h0);
    check_eq("t3 outstanding 1", 64'(outstanding), 64'h1);
    tick();
    check_eq("t3 single pop", 64'(master_awvalid | master_wvalid), 64'h0);
    b_drain(1);
    check_eq("t3 busy idle", 64'(busy), 64'h0);

    // Outstanding limit with bready held low.
    master_awready = 1'b1; master_wready = 1'b1;
    aw_i = 0; w_i = 0; p_i = 0;
    for (int c = 1; c <= 16; c++) begin
      if (aw_i < 6) begin slave_awvalid = 1'b1; slave_awaddr = 1'(aw_i); end
      else slave_awvalid = 1'b0;
      if (w_i < 6) begin slave_wvalid = 1'b1; slave_wdata = 32'hA0 + 32'(w_i); slave_wstrb = 4'hF; end
      else slave_wvalid = 1'b0;
      #1;
      aw_fire = slave_awvalid && slave_awready;
      w_fire  = slave_wvalid && slave_wready;
      if (master_awvalid && master_wvalid) p_i++;
      tick();
      if (aw_fire) aw_i++;
      if (w_fire) w_i++;
    end
    slave_awvalid = 1'b0; slave_wvalid = 1'b0;
    check_eq("t4 issued", 64'(p_i), 64'h4);
    check_eq("t4 outstanding max", 64'(outstanding), 64'h4);
    check_eq("t4 stalled", 64'(master_awvalid), 64'h0);
    check_eq("t4 busy", 64'(busy), 64'h1);
    master_bvalid = 1'b1; slave_bready = 1'b1;
    tick();
    master_bvalid = 1'b0; slave_bready = 1'b0;
    check_eq("t4 after b", 64'(outstanding), 64'h3);
    tick();
    check_eq("t4 fifth awvalid", 64'(master_awvalid), 64'h1);
    check_eq("t4 fifth wdata", 64'(master_wdata), 64'hA4);
    check_eq("t4 fifth awaddr", 64'(master_awaddr), 64'h0);
    tick();
    check_eq("t4 outstanding back", 64'(outstanding), 64'h4);
    check_eq("t4 sixth held", 64'(master_awvalid), 64'h0);

    // Simultaneous pair completion and B handshake at outstanding 2.
    master_awready = 1'b0; master_wready = 1'b0;
    master_bvalid = 1'b1; slave_bready = 1'b1;
    tick(); tick();
    master_bvalid = 1'b0; slave_bready = 1'b0;
    check_eq("t5 outstanding 2", 64'(outstanding), 64'h2);
    check_eq("t5 sixth issued", 64'(master_awvalid), 64'h1);
    check_eq("t5 sixth wdata", 64'(master_wdata), 64'hA5);
    master_awready = 1'b1; master_wready = 1'b1; master_bvalid = 1'b1; slave_bready = 1'b1;
    tick();
    master_awready = 1'b0; master_wready = 1'b0; master_bvalid = 1'b0; slave_bready = 1'b0;
    check_eq("t5 simultaneous", 64'(outstanding), 64'h2);
    check_eq("t5 fifo empty", 64'(master_awvalid), 64'h0);
    b_drain(2);
    check_eq("t5 drained busy", 64'(busy), 64'h0);

    // Read channel pass-through.
    slave_arvalid = 1'b1; slave_araddr = 1'b1; slave_arprot = 3'd5; master_arready = 1'b1;
    master_rvalid = 1'b1; master_rdata = 32'h12345678; master_rresp = 2'b01; slave_rready = 1'b1;
    #1;
    check_eq("rd arvalid", 64'(master_arvalid), 64'h1);
    check_eq("rd araddr", 64'(master_araddr), 64'h1);
    check_eq("rd arprot", 64'(master_arprot), 64'h5);
    check_eq("rd arready", 64'(slave_arready), 64'h1);
    check_eq("rd rvalid", 64'(slave_rvalid), 64'h1);
    check_eq("rd rdata", 64'(slave_rdata), 64'h12345678);
    check_eq("rd rresp", 64'(slave_rresp), 64'h1);
    check_eq("rd rready", 64'(master_rready), 64'h1);
    slave_arvalid = 1'b0; master_arready = 1'b0; master_rvalid = 1'b0; slave_rready = 1'b0;
    tick();

    // Reset while in W_DONE with two AWs queued.
    master_awready = 1'b0; master_wready = 1'b1;
    slave_awvalid = 1'b1; slave_awaddr = 1'b1;
    slave_wvalid = 1'b1; slave_wdata = 32'h55555555; slave_wstrb = 4'hF;
    tick();
    slave_wvalid = 1'b0; slave_awaddr = 1'b0;
    tick();
    slave_awvalid = 1'b0;
    tick();
    check_eq("t6 wdone awvalid", 64'(master_awvalid), 64'h1);
    check_eq("t6 wdone wvalid", 64'(master_wvalid), 64'h0);
    check_eq("t6 aw full", 64'(slave_awready), 64'h0);
    areset = 1'b1;
    #1;
    check_eq("t6 rst awready", 64'(slave_awready), 64'h0);
    check_eq("t6 rst wready", 64'(slave_wready), 64'h0);
    check_eq("t6 rst awvalid", 64'(master_awvalid), 64'h0);
    check_eq("t6 rst wvalid", 64'(master_wvalid), 64'h0);
    check_eq("t6 rst outstanding", 64'(outstanding), 64'h0);
    check_eq("t6 rst busy", 64'(busy), 64'h0);
    tick();
    areset = 1'b0;
    master_awready = 1'b1; master_wready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("t6 no stale %0d", k), 64'(master_awvalid | master_wvalid), 64'h0);
    end
    check_eq("t6 awready back", 64'(slave_awready), 64'h1);
    check_eq("t6 busy", 64'(busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
